io_event_conditioner: RTL and testbench
=======================================

IO_EVENT_CONDITIONER -- requirements
Module: io_event_conditioner

Interface
REQ-001 SHALL have parameter FILTER_WIDTH, default 4, the width of the filter length field and of the filter counter.
REQ-002 SHALL have port clk_i, input, 1, the clock; all state is updated on the rising edge.
REQ-003 SHALL have port rstn_i, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port event_async_i, input, 1, the raw pad/peripheral event; it is asynchronous to clk_i.
REQ-005 SHALL have port enable_i, input, 1; when low, event_o and glitch_o are gated off and the filter keeps tracking.
REQ-006 SHALL have port clr_i, input, 1, a synchronous clear of the filter, outputs and glitch count.
REQ-007 SHALL have port edge_sel_i, input, 2: 00 rising, 01 falling, 10 both edges, 11 level-high.
REQ-008 SHALL have port filter_len_i, input, FILTER_WIDTH, the number of consecutive stable cycles required; values 0 and 1 are equivalent.
REQ-009 SHALL have port event_o, output, 1, the conditioned event; it drives the event_i input of the downstream event counter.
REQ-010 SHALL have port level_o, output, 1, the filtered level.
REQ-011 SHALL have port glitch_o, output, 1, a single-cycle pulse issued when a pending transition is rejected.
REQ-012 SHALL have port glitch_cnt_o, output, 8, a saturating count of rejected transitions.

Function
REQ-013 SHALL pass event_async_i through a 2-FF synchronizer (sync1, then sync2); no other logic reads sync1.
REQ-014 SHALL hold the filtered level filt and the counter cnt (FILTER_WIDTH bits); level_o = filt.
REQ-015 SHALL, each cycle with sync2 == filt: set cnt to 0; if cnt != 0, the pending transition is rejected (REQ-018).
REQ-016 SHALL, each cycle with sync2 != filt and cnt >= max(filter_len_i,1)-1: load filt with sync2 and set cnt to 0 (transition accepted).
REQ-017 SHALL, each cycle with sync2 != filt otherwise: increment cnt; cnt never wraps, because the acceptance condition is reached first.
REQ-018 SHALL, on rejection, register glitch_o = enable_i for exactly one cycle and increment glitch_cnt_o if enable_i is high; glitch_cnt_o saturates at 255.
REQ-019 SHALL register event_o:
- Edge modes: high for exactly one cycle, the same cycle in which filt first shows the accepted value.
- Rising: only for a 0->1 acceptance. Falling: only for a 1->0 acceptance. Both: for either.
REQ-020 SHALL, in level mode (11), set event_o = filt, registered one cycle after filt.
REQ-021 SHALL force event_o low while enable_i is low; an acceptance that occurs while disabled is lost, not deferred.
REQ-022 SHALL have latency from the clock edge at which sync1 captures a new stable value to event_o high of 2 + max(filter_len_i,1) - 1 = 1 + max(filter_len_i,1) cycles.
REQ-023 SHALL apply changes to edge_sel_i or filter_len_i from the next cycle; lowering filter_len_i below the current cnt causes acceptance on the next differing cycle.
REQ-024 SHALL, on clr_i, set cnt=0, filt=sync2, event_o=0, glitch_o=0 and glitch_cnt_o=0 without generating any event; clr_i has priority over all other updates in the same cycle.
REQ-025 SHALL, with acceptance and rejection conditions both present, treat them as mutually exclusive by construction (equality test); no simultaneous pulse on event_o and glitch_o from the same cycle's evaluation.

Reset
REQ-026 SHALL, on rstn_i low, asynchronously clear sync1, sync2, filt, cnt, event_o, level_o, glitch_o and glitch_cnt_o to 0.
REQ-027 SHALL, when reset is released while event_async_i is high, treat the input as a normal 0->1 transition (rising event after the filter delay).

Verification
REQ-028 SHALL be verified: filter_len=3, rising mode, input 0->1 held 10 cycles -> level_o rises 4 cycles after the sync1 capture, event_o one pulse, glitch_cnt_o=0.
REQ-029 SHALL be verified: filter_len=3, a 2-cycle high glitch -> no event_o, level_o stays 0, glitch_o one pulse, glitch_cnt_o=1.
REQ-030 SHALL be verified: both mode, filter_len=0, input toggles every 4 cycles for 8 toggles -> exactly 8 single-cycle event_o pulses, each 2 cycles after its sync1 capture.
REQ-031 SHALL be verified: level mode, input high for 6 stable cycles -> event_o high for 6 cycles, delayed by filt latency + 1.
REQ-032 SHALL be verified: enable_i low during an accepted rising edge, then enable_i high -> no event_o, level_o=1.
REQ-033 SHALL be verified: 300 rejected glitches -> glitch_cnt_o=255; then clr_i -> 0, with no event_o; rstn_i asserted mid-filter (cnt=2) -> all outputs 0 immediately.

Source files
------------

// File: rtl/io_event_conditioner.sv
// Synchronizes an asynchronous pad/peripheral event, debounces it with a programmable
// stability filter and emits edge or level events plus glitch (rejected transition) reporting.
module io_event_conditioner #(
    parameter int unsigned FILTER_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    event_async_i,
    input  logic                    enable_i,
    input  logic                    clr_i,
    input  logic [1:0]              edge_sel_i,
    input  logic [FILTER_WIDTH-1:0] filter_len_i,
    output logic                    event_o,
    output logic                    level_o,
    output logic                    glitch_o,
    output logic [7:0]              glitch_cnt_o
);

    typedef enum logic [1:0] {
        SEL_RISE  = 2'b00,
        SEL_FALL  = 2'b01,
        SEL_BOTH  = 2'b10,
        SEL_LEVEL = 2'b11
    } edge_sel_e;

    logic                    sync1_q, sync2_q;
    logic                    filt_q, filt_d;
    logic [FILTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                    event_q, event_d;
    logic                    glitch_q, glitch_d;
    logic [7:0]              gcnt_q, gcnt_d;

    logic [FILTER_WIDTH-1:0] thr;
    logic                    differ;
    logic                    accept;

    // Lengths 0 and 1 both mean "accept on the first differing cycle".
    assign thr    = (filter_len_i == '0) ? '0 : filter_len_i - 1'b1;
    assign differ = (sync2_q != filt_q);
    assign accept = differ && (cnt_q >= thr);

    // NOTE: every _d signal gets a default at the top so no path through the block infers a latch.
    always_comb begin
        filt_d   = filt_q;
        cnt_d    = cnt_q;
        event_d  = 1'b0;
        glitch_d = 1'b0;
        gcnt_d   = gcnt_q;
        if (clr_i) begin
            filt_d = sync2_q;
            cnt_d  = '0;
            gcnt_d = '0;
        end else begin
            if (!differ) begin
                cnt_d = '0;
                if (cnt_q != '0) begin
                    glitch_d = enable_i;
                    if (enable_i && (gcnt_q != 8'hFF)) gcnt_d = gcnt_q + 8'd1;
                end
            end else if (accept) begin
                filt_d = sync2_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            // Edge modes pulse with the new filt; level mode follows the old filt one cycle later.
            case (edge_sel_e'(edge_sel_i))
                SEL_RISE:  event_d = enable_i && accept && sync2_q;
                SEL_FALL:  event_d = enable_i && accept && !sync2_q;
                SEL_BOTH:  event_d = enable_i && accept;
                SEL_LEVEL: event_d = enable_i && filt_q;
                default:   event_d = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            filt_q   <= 1'b0;
            cnt_q    <= '0;
            event_q  <= 1'b0;
            glitch_q <= 1'b0;
            gcnt_q   <= 8'd0;
        end else begin
            sync1_q  <= event_async_i;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            event_q  <= event_d;
            glitch_q <= glitch_d;
            gcnt_q   <= gcnt_d;
        end
    end

    assign event_o      = event_q;
    assign level_o      = filt_q;
    assign glitch_o     = glitch_q;
    assign glitch_cnt_o = gcnt_q;

endmodule

// File: tb/tb_io_event_conditioner.sv
// Self-checking bench for io_event_conditioner: table-driven pulse vectors with an event-time
// scoreboard, plus hand-written sequences for reset, level mode, enable gating and saturation.
module tb_io_event_conditioner;

    localparam int FW = 4;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          event_async_i;
    logic          enable_i;
    logic          clr_i;
    logic [1:0]    edge_sel_i;
    logic [FW-1:0] filter_len_i;
    logic          event_o;
    logic          level_o;
    logic          glitch_o;
    logic [7:0]    glitch_cnt_o;

    io_event_conditioner #(.FILTER_WIDTH(FW)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .event_async_i(event_async_i),
        .enable_i     (enable_i),
        .clr_i        (clr_i),
        .edge_sel_i   (edge_sel_i),
        .filter_len_i (filter_len_i),
        .event_o      (event_o),
        .level_o      (level_o),
        .glitch_o     (glitch_o),
        .glitch_cnt_o (glitch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Scoreboard of expected event_o cycles, pushed when the stimulus edge is driven.
    int exp_q[$];
    bit mon_on = 1'b0;
    bit sb_on  = 1'b0;
    int ev_cnt = 0;
    int gl_cnt = 0;
    int ev_first = -1;

    always @(negedge clk_i) begin
        if (mon_on) begin
            if (event_o) begin
                ev_cnt++;
                if (ev_first < 0) ev_first = cyc;
                if (sb_on) begin
                    check("sb_event_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("sb_event_cycle", cyc, exp_q.pop_front());
                end
            end
            if (glitch_o) gl_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic reset_counters();
        ev_cnt   = 0;
        gl_cnt   = 0;
        ev_first = -1;
    endtask

    // Hold the input stable, then clear so filt matches the synchronized level.
    task automatic settle(input logic lvl, input logic [1:0] sel, input logic [FW-1:0] flen);
        mon_on        = 1'b0;
        event_async_i = lvl;
        edge_sel_i    = sel;
        filter_len_i  = flen;
        tick(4);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        tick(1);
        reset_counters();
        mon_on = 1'b1;
    endtask

    typedef struct {
        logic [1:0]    sel;
        logic [FW-1:0] flen;
        logic          start;
        int            pulse;
        int            exp_events;
        int            exp_glitches;
    } vec_t;

    vec_t vecs[8];

    initial begin
        // {edge_sel, filter_len, start level, pulse length, events, glitches}
        vecs[0] = '{2'b00, 4'd3,  1'b0, 10, 1, 0};
        vecs[1] = '{2'b00, 4'd3,  1'b0, 2,  0, 1};
        vecs[2] = '{2'b01, 4'd3,  1'b1, 5,  1, 0};
        vecs[3] = '{2'b01, 4'd2,  1'b0, 4,  1, 0};
        vecs[4] = '{2'b10, 4'd0,  1'b0, 1,  2, 0};
        vecs[5] = '{2'b10, 4'd4,  1'b1, 3,  0, 1};
        vecs[6] = '{2'b00, 4'd1,  1'b1, 6,  1, 0};
        vecs[7] = '{2'b10, 4'd15, 1'b0, 14, 0, 1};

        rstn_i        = 1'b0;
        event_async_i = 1'b1;
        enable_i      = 1'b1;
        clr_i         = 1'b0;
        edge_sel_i    = 2'b00;
        filter_len_i  = 4'd3;
        tick(2);
        check("rst_event_o", int'(event_o), 0);
        check("rst_level_o", int'(level_o), 0);
        check("rst_glitch_o", int'(glitch_o), 0);
        check("rst_glitch_cnt", int'(glitch_cnt_o), 0);

        // Reset released with the input already high: treated as a rising transition.
        mon_on = 1'b1;
        sb_on  = 1'b1;
        exp_q.push_back(cyc + 5);
        rstn_i = 1'b1;
        tick(12);
        check("rstrel_events", ev_cnt, 1);
        check("rstrel_level", int'(level_o), 1);
        check("rstrel_sb_empty", exp_q.size(), 0);

        foreach (vecs[i]) begin
            int lp;
            int d;
            settle(vecs[i].start, vecs[i].sel, vecs[i].flen);
            lp = (vecs[i].flen == 0) ? 1 : int'(vecs[i].flen);
            d  = cyc;
            if (vecs[i].pulse >= lp) begin
                logic first_rise;
                first_rise = !vecs[i].start;
                if (vecs[i].sel == 2'b10 || (vecs[i].sel == 2'b00) == first_rise)
                    exp_q.push_back(d + 2 + lp);
                if (vecs[i].sel == 2'b10 || (vecs[i].sel == 2'b00) == !first_rise)
                    exp_q.push_back(d + vecs[i].pulse + 2 + lp);
            end
            event_async_i = !vecs[i].start;
            tick(vecs[i].pulse);
            event_async_i = vecs[i].start;
            tick(24);
            check($sformatf("vec%0d_events", i), ev_cnt, vecs[i].exp_events);
            check($sformatf("vec%0d_glitch_cnt", i), int'(glitch_cnt_o), vecs[i].exp_glitches);
            check($sformatf("vec%0d_glitch_pulses", i), gl_cnt, vecs[i].exp_glitches);
            check($sformatf("vec%0d_level", i), int'(level_o), int'(vecs[i].start));
            check($sformatf("vec%0d_sb_empty", i), exp_q.size(), 0);
        end

        // Both edges, no filtering: 8 toggles every 4 cycles, each event 2 cycles after capture.
        settle(1'b0, 2'b10, 4'd0);
        for (int t = 0; t < 8; t++) begin
            exp_q.push_back(cyc + 3);
            event_async_i = ~event_async_i;
            tick(4);
        end
        tick(10);
        check("both_events", ev_cnt, 8);
        check("both_sb_empty", exp_q.size(), 0);
        check("both_glitches", gl_cnt, 0);

        // Level mode: 6 stable high cycles give 6 event_o cycles one cycle behind filt.
        begin
            int d;
            settle(1'b0, 2'b11, 4'd3);
            sb_on = 1'b0;
            d = cyc;
            event_async_i = 1'b1;
            tick(6);
            event_async_i = 1'b0;
            tick(20);
            check("level_high_cycles", ev_cnt, 6);
            check("level_first_cycle", ev_first, d + 6);
            check("level_final", int'(level_o), 0);
            sb_on = 1'b1;
        end

        // Disabled: glitch not reported, acceptance lost rather than deferred.
        settle(1'b0, 2'b00, 4'd3);
        enable_i      = 1'b0;
        event_async_i = 1'b1;
        tick(1);
        event_async_i = 1'b0;
        tick(6);
        check("dis_glitch_pulses", gl_cnt, 0);
        check("dis_glitch_cnt", int'(glitch_cnt_o), 0);
        event_async_i = 1'b1;
        tick(8);
        enable_i = 1'b1;
        tick(10);
        check("dis_events", ev_cnt, 0);
        check("dis_level", int'(level_o), 1);

        // Glitch count saturation, clear, then reset in the middle of filtering.
        settle(1'b0, 2'b00, 4'd3);
        for (int g = 0; g < 300; g++) begin
            event_async_i = 1'b1;
            tick(1);
            event_async_i = 1'b0;
            tick(3);
        end
        tick(4);
        check("sat_glitch_cnt", int'(glitch_cnt_o), 255);
        check("sat_glitch_pulses", gl_cnt, 300);
        check("sat_events", ev_cnt, 0);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        check("clr_glitch_cnt", int'(glitch_cnt_o), 0);
        check("clr_event_o", int'(event_o), 0);
        tick(4);
        check("clr_events", ev_cnt, 0);
        for (int g = 0; g < 3; g++) begin
            event_async_i = 1'b1;
            tick(1);
            event_async_i = 1'b0;
            tick(3);
        end
        tick(2);
        check("post_clr_glitch_cnt", int'(glitch_cnt_o), 3);
        event_async_i = 1'b1;
        tick(4);
        check("midfilt_level_before", int'(level_o), 0);
        rstn_i = 1'b0;
        #1;
        check("midrst_event_o", int'(event_o), 0);
        check("midrst_level_o", int'(level_o), 0);
        check("midrst_glitch_o", int'(glitch_o), 0);
        check("midrst_glitch_cnt", int'(glitch_cnt_o), 0);
        mon_on = 1'b0;
        event_async_i = 1'b0;
        tick(2);
        rstn_i = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
